// File: rtl/inst_pkg.sv
// Shared constants for the MIPS instruction encoder: format selectors and the
// bit positions of each field inside a 32-bit instruction word.
package inst_pkg;

    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_J = 2'd2;
    localparam logic [1:0] FMT_C = 2'd3;

    localparam int OPCODE_HI = 31;
    localparam int RS_LO     = 21;
    localparam int RT_LO     = 16;
    localparam int RD_LO     = 11;
    localparam int SA_LO     = 6;
    localparam int CODE_LO   = 6;

endpackage

// File: rtl/inst_encode_if.sv
// Producer-side field bundle and consumer-side instruction stream of the encoder.
// master drives fields and out_ready; slave is the encoder queue itself.
interface inst_encode_if;

    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_fmt;
    logic [5:0]  in_opcode;
    logic [5:0]  in_funct;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_sa;
    logic [15:0] in_imm;
    logic [25:0] in_instIndex;
    logic [19:0] in_code;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;

    modport master (
        output in_valid, in_fmt, in_opcode, in_funct, in_rs, in_rt, in_rd,
               in_sa, in_imm, in_instIndex, in_code, out_ready,
        input  in_ready, out_valid, out_inst
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_funct, in_rs, in_rt, in_rd,
               in_sa, in_imm, in_instIndex, in_code, out_ready,
        output in_ready, out_valid, out_inst
    );

endinterface

// File: rtl/inst_pack.sv
// Combinational packer: places decoded fields into a 32-bit word according to
// the selected format; the exact inverse of ID-stage field extraction.
module inst_pack
    import inst_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  sa,
    input  logic [15:0] imm,
    input  logic [25:0] inst_index,
    input  logic [19:0] code,
    output logic [31:0] inst
);

    always_comb begin
        // NOTE: assigning a default before the case keeps every bit driven on every path, so no latch is inferred.
        inst = '0;
        inst[OPCODE_HI -: 6] = opcode;
        case (fmt)
            FMT_R: begin
                inst[RS_LO +: 5] = rs;
                inst[RT_LO +: 5] = rt;
                inst[RD_LO +: 5] = rd;
                inst[SA_LO +: 5] = sa;
                inst[5:0]        = funct;
            end
            FMT_I: begin
                inst[RS_LO +: 5] = rs;
                inst[RT_LO +: 5] = rt;
                inst[15:0]       = imm;
            end
            FMT_J: inst[25:0] = inst_index;
            default: begin
                inst[CODE_LO +: 20] = code;
                inst[5:0]           = funct;
            end
        endcase
    end

endmodule

// File: rtl/inst_encode.sv
// Instruction encoder and injection queue: packs field bundles into words and
// buffers them in a first-word-fall-through FIFO drained by fetch/debug logic.
module inst_encode
    import inst_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    inst_encode_if.slave               bus,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   packed_word;
    logic          push;
    logic          pop;

    inst_pack u_pack (
        .fmt        (bus.in_fmt),
        .opcode     (bus.in_opcode),
        .funct      (bus.in_funct),
        .rs         (bus.in_rs),
        .rt         (bus.in_rt),
        .rd         (bus.in_rd),
        .sa         (bus.in_sa),
        .imm        (bus.in_imm),
        .inst_index (bus.in_instIndex),
        .code       (bus.in_code),
        .inst       (packed_word)
    );

    // Handshake flags come from registered count only, never from valid/ready inputs.
    assign bus.in_ready  = (count < CW'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign bus.out_inst  = bus.out_valid ? mem[rd_ptr] : 32'h0;

    assign push = bus.in_valid  & bus.in_ready  & ~flush;
    assign pop  = bus.out_valid & bus.out_ready & ~flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: storage has no reset; valid data is tracked by count, so clearing it would only cost flops.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= packed_word;
    end

endmodule

// File: tb/tb_inst_encode.sv
// Randomized self-checking bench for inst_encode against a queue-based reference
// model that packs words straight from the field-layout rules.
module tb_inst_encode;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic          flush  = 1'b0;
    logic [CW-1:0] count;

    inst_encode_if bus ();

    inst_encode #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (bus),
        .count  (count)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] q[$];

    function automatic logic [31:0] ref_word(
        input logic [1:0] f, input logic [5:0] op, input logic [5:0] fn,
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
        input logic [4:0] sa, input logic [15:0] imm, input logic [25:0] idx,
        input logic [19:0] code);
        case (f)
            2'd0:    return {op, rs, rt, rd, sa, fn};
            2'd1:    return {op, rs, rt, imm};
            2'd2:    return {op, idx};
            default: return {op, code, fn};
        endcase
    endfunction

    function automatic logic [31:0] cur_word();
        return ref_word(bus.in_fmt, bus.in_opcode, bus.in_funct, bus.in_rs, bus.in_rt,
                        bus.in_rd, bus.in_sa, bus.in_imm, bus.in_instIndex, bus.in_code);
    endfunction

    task automatic set_fields(input logic [1:0] f, input logic [5:0] op, input logic [5:0] fn,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [4:0] sa, input logic [15:0] imm,
                              input logic [25:0] idx, input logic [19:0] code);
        bus.in_fmt = f;   bus.in_opcode = op; bus.in_funct = fn;
        bus.in_rs = rs;   bus.in_rt = rt;     bus.in_rd = rd;     bus.in_sa = sa;
        bus.in_imm = imm; bus.in_instIndex = idx; bus.in_code = code;
    endtask

    task automatic rand_fields();
        set_fields(2'($urandom), 6'($urandom), 6'($urandom), 5'($urandom), 5'($urandom),
                   5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom), 20'($urandom));
    endtask

    // Advance one clock and apply the same transfer to the model queue.
    task automatic tick();
        bit          do_push;
        bit          do_pop;
        logic [31:0] w;
        do_push = resetn && !flush && bus.in_valid && (q.size() < DEPTH);
        do_pop  = resetn && !flush && bus.out_ready && (q.size() > 0);
        w = cur_word();
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(w);
        end
        #1;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH && bus.out_valid; i++) tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        rand_fields();
        #12;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_inst !== 32'h0 || count !== '0) begin
            failures++;
            $display("FAIL reset_state got ready=%b valid=%b inst=%h count=%0d exp 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_inst, count);
        end
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_r_type();
        set_fields(2'd0, 6'd0, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'hABCD, 26'h3FFFFFF, 20'hFFFFF);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_inst !== 32'h00221820 || bus.out_valid !== 1'b1 || count !== CW'(1)) begin
            failures++;
            $display("FAIL r_type got inst=%h valid=%b count=%0d exp 00221820 1 1",
                     bus.out_inst, bus.out_valid, count);
        end
        drain();
    endtask

    task automatic test_i_type();
        set_fields(2'd1, 6'h09, 6'h3F, 5'd0, 5'd8, 5'h1F, 5'h1F, 16'hFFFF, 26'h155AAAA, 20'h12345);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_inst !== 32'h2408FFFF) begin
            failures++;
            $display("FAIL i_type got=%h exp=2408ffff", bus.out_inst);
        end
        drain();
    endtask

    task automatic test_j_c();
        bus.in_valid = 1'b1;
        set_fields(2'd2, 6'h02, 6'h3F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 16'hFFFF, 26'h0100000, 20'hFFFFF);
        tick();
        set_fields(2'd3, 6'h00, 6'h0C, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 16'hFFFF, 26'h3FFFFFF, 20'h00001);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (count !== CW'(2) || bus.out_inst !== 32'h08100000) begin
            failures++;
            $display("FAIL j_head got inst=%h count=%0d exp 08100000 2", bus.out_inst, count);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_inst !== 32'h0000004C) begin
            failures++;
            $display("FAIL c_second got=%h exp=0000004c", bus.out_inst);
        end
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_inst !== 32'h0) begin
            failures++;
            $display("FAIL empty_after_jc got valid=%b inst=%h exp 0 0", bus.out_valid, bus.out_inst);
        end
    endtask

    task automatic test_full();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rand_fields();
            tick();
        end
        checks++;
        if (bus.in_ready !== 1'b0 || count !== CW'(DEPTH)) begin
            failures++;
            $display("FAIL full got ready=%b count=%0d exp 0 %0d", bus.in_ready, count, DEPTH);
        end
        rand_fields();
        tick();
        checks++;
        if (count !== CW'(DEPTH) || bus.out_inst !== q[0]) begin
            failures++;
            $display("FAIL full_reject got count=%0d inst=%h exp %0d %h", count, bus.out_inst, DEPTH, q[0]);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (count !== CW'(DEPTH - 1) || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_no_bypass got count=%0d ready=%b exp %0d 1", count, bus.in_ready, DEPTH - 1);
        end
        tick();
        checks++;
        if (count !== CW'(DEPTH - 1) || bus.out_inst !== q[0]) begin
            failures++;
            $display("FAIL full_push_pop got count=%0d inst=%h exp %0d %h", count, bus.out_inst, DEPTH - 1, q[0]);
        end
        drain();
    endtask

    task automatic test_wrap();
        logic [31:0] exp_list[$];
        int          pushed = 0;
        int          got    = 0;
        rand_fields();
        for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
            bit accepted;
            bus.in_valid  = (pushed < 10);
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (bus.out_inst !== exp_list[got]) begin
                    failures++;
                    $display("FAIL wrap_order idx=%0d got=%h exp=%h", got, bus.out_inst, exp_list[got]);
                end
                got++;
            end
            accepted = bus.in_valid && bus.in_ready;
            if (accepted) begin
                exp_list.push_back(cur_word());
                pushed++;
            end
            tick();
            if (accepted) rand_fields();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        checks++;
        if (got != 10) begin
            failures++;
            $display("FAIL wrap_count got=%0d exp=10", got);
        end
        drain();
    endtask

    task automatic test_flush();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_fields();
            tick();
        end
        checks++;
        if (count !== CW'(3)) begin
            failures++;
            $display("FAIL flush_pre got count=%0d exp 3", count);
        end
        flush = 1'b1; bus.out_ready = 1'b1;
        rand_fields();
        tick();
        flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        checks++;
        if (count !== '0 || bus.out_valid !== 1'b0 || bus.out_inst !== 32'h0) begin
            failures++;
            $display("FAIL flush got count=%0d valid=%b inst=%h exp 0 0 0", count, bus.out_valid, bus.out_inst);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        bus.in_valid = 1'b1;
        rand_fields(); tick();
        rand_fields(); tick();
        bus.in_valid = 1'b0;
        checks++;
        if (count !== CW'(2)) begin
            failures++;
            $display("FAIL reset_mid_pre got count=%0d exp 2", count);
        end
        #3 resetn = 1'b0;
        q.delete();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || count !== '0 || bus.out_inst !== 32'h0) begin
            failures++;
            $display("FAIL reset_async got valid=%b ready=%b count=%0d inst=%h exp 0 1 0 0",
                     bus.out_valid, bus.in_ready, count, bus.out_inst);
        end
        @(posedge clk); #2 resetn = 1'b1;
        @(posedge clk); #1;
        rand_fields();
        w = cur_word();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (count !== CW'(1) || bus.out_valid !== 1'b1 || bus.out_inst !== w) begin
            failures++;
            $display("FAIL reset_mid_after got count=%0d valid=%b inst=%h exp 1 1 %h",
                     count, bus.out_valid, bus.out_inst, w);
        end
        drain();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [31:0] exp_inst;
            bit          stalled;
            stalled = bus.in_valid && !bus.in_ready;
            if (!stalled) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                rand_fields();
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 19) == 0);
            #1;
            exp_inst = (q.size() > 0) ? q[0] : 32'h0;
            checks++;
            if (bus.out_valid !== (q.size() > 0) || count !== CW'(q.size()) ||
                bus.in_ready !== (q.size() < DEPTH) || bus.out_inst !== exp_inst) begin
                failures++;
                $display("FAIL random cyc=%0d got valid=%b count=%0d ready=%b inst=%h exp %b %0d %b %h",
                         cyc, bus.out_valid, count, bus.in_ready, bus.out_inst,
                         q.size() > 0, q.size(), q.size() < DEPTH, exp_inst);
            end
            tick();
        end
        flush = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_r_type();
        test_i_type();
        test_j_c();
        test_full();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_encode.md
# inst_encode

Instruction encoder and injection queue. It accepts decoded MIPS instruction fields plus a format selector over a valid/ready handshake. It packs them into 32-bit instruction words and buffers those words in a small FIFO. The fetch/debug-injection path drains the FIFO over a second valid/ready handshake. Its field layout is the exact inverse of the ID-stage field extraction (opcode/rs/rt/rd/sa/funct/imm/instIndex/code).

## Interface

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of queue contents.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  queue can accept; equals (count < DEPTH).
- in_fmt  in  2  0=R, 1=I, 2=J, 3=C (code-type: syscall/break).
- in_opcode  in  6  opcode, bits [31:26].
- in_funct  in  6  funct, bits [5:0] (R, C).
- in_rs  in  5  rs/base, bits [25:21] (R, I).
- in_rt  in  5  rt, bits [20:16] (R, I).
- in_rd  in  5  rd, bits [15:11] (R).
- in_sa  in  5  sa, bits [10:6] (R).
- in_imm  in  16  imm/offset, bits [15:0] (I).
- in_instIndex  in  26  jump index, bits [25:0] (J).
- in_code  in  20  code, bits [25:6] (C).
- out_valid  out  1  queue non-empty.
- out_ready  in  1  consumer accepts head word.
- out_inst  out  32  head instruction word; 0 when out_valid=0.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation

- Packing (combinational, on input fields):
  - R: {opcode, rs, rt, rd, sa, funct}.
  - I: {opcode, rs, rt, imm}.
  - J: {opcode, instIndex}.
  - C: {opcode, code, funct}.
- Fields not used by the selected format are ignored. No opcode/format consistency check.
- Push = in_valid & in_ready & ~flush. The packed word is written at wr_ptr, and wr_ptr advances modulo DEPTH.
- Pop = out_valid & out_ready & ~flush. rd_ptr advances modulo DEPTH.
- count += push − pop. Simultaneous push and pop leave count unchanged.
- Full (count=DEPTH): in_ready=0, so no push. There is no same-cycle bypass even if a pop occurs.
- Empty: out_valid=0, out_inst=0, and out_ready is ignored.
- Head is first-word-fall-through: out_inst = mem[rd_ptr] while out_valid=1. out_inst is stable until popped.
- flush: next cycle count=0 and wr_ptr=rd_ptr=0. Any concurrent push and pop are discarded.
- Reset (asynchronous, any time including mid-transfer):
  - count=0, pointers=0.
  - Outputs: in_ready=1, out_valid=0, out_inst=0.
  - Memory contents are not cleared.

## Timing

- Latency: a word pushed into an empty queue at edge N is visible at out_inst with out_valid=1 after edge N (from cycle N+1).
- Throughput: one push and one pop per cycle sustained.
- in_ready, out_valid and count derive only from registered count; there is no combinational path from in_valid or out_ready.
- out_inst is a mux from registered storage, with no path from in_* fields.
- Handshake rules:
  - The producer holds fields stable while in_valid=1 and in_ready=0.
  - The consumer may drop out_ready at any cycle.
  - A transfer happens only on a cycle where both valid and ready are high.

## Structure

- Shared package (inst_pkg):
  - format constants FMT_R=2'd0, FMT_I=2'd1, FMT_J=2'd2, FMT_C=2'd3.
  - field bit-position constants (OPCODE_HI=31, RS_LO=21, RT_LO=16, RD_LO=11, SA_LO=6, CODE_LO=6).
- Sub-module inst_pack: purely combinational, in_fmt + fields → 32-bit word. Independently testable.
- The FIFO (pointers, count, storage array) is implemented inline in inst_encode.

## Test plan

- R-type `add $3,$1,$2`: fmt=0, opcode=0, rs=1, rt=2, rd=3, sa=0, funct=0x20 → out_inst=0x00221820 one cycle after push, count=1.
- I-type `addiu $8,$0,-1`: fmt=1, opcode=0x09, rs=0, rt=8, imm=0xFFFF (rd/sa/funct driven 0x1F/0x1F/0x3F) → 0x2408FFFF, ignored fields have no effect.
- J and C: fmt=2, opcode=0x02, instIndex=0x0100000 → 0x08100000; then fmt=3, opcode=0, code=0x00001, funct=0x0C → 0x0000004C, popped in push order.
- Full/boundary:
  - Push 4 words with out_ready=0 → in_ready=0 after 4th, count=4, fifth in_valid not accepted.
  - Then out_ready=1 with in_valid=1 → one pop per cycle, and a push is accepted from the cycle after count drops to 3.
  - Pointer wrap preserves order across 10 words.
- Flush: count=3, assert flush with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, out_inst=0, no word delivered.
- Reset mid-op: count=2, drop resetn asynchronously mid-cycle → out_valid=0, in_ready=1, count=0 immediately; after release, first new push appears as sole head.
